// File: rtl/timer_seq.sv
// Sequencer that programs, arms and acknowledges the count-up timer,
// and shares the timer register port with the host bus.
module timer_seq #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] CTRL_ARM = 32'h7,
    parameter logic [31:0] CTRL_CLR = 32'h4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start_i,
    input  logic             cfg_stop_i,
    input  logic [31:0]      cfg_period_i,
    input  logic [CNT_W-1:0] cfg_reload_i,
    input  logic             irq_ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             irq_o,
    output logic [CNT_W-1:0] period_cnt_o,
    input  logic             m_req_i,
    input  logic             m_we_i,
    input  logic [31:0]      m_addr_i,
    input  logic [31:0]      m_data_i,
    output logic [31:0]      m_data_o,
    output logic             m_ack_o,
    output logic             t_req_o,
    output logic             t_we_o,
    output logic [31:0]      t_addr_o,
    output logic [31:0]      t_data_o,
    input  logic [31:0]      t_data_i,
    input  logic             t_int_i
);

    localparam logic [31:0] ADDR_CTRL  = 32'h0;
    localparam logic [31:0] ADDR_VALUE = 32'h8;

    typedef enum logic [2:0] {
        IDLE, WR_VAL, WR_ARM, RUN, WR_CLR, WR_STOP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       period_q;
    logic [CNT_W-1:0]  reload_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              irq_q;

    logic              start_ok;
    logic              stop_ok;
    logic              expire;
    logic              last;
    logic              seq_wr;
    logic [31:0]       seq_addr;
    logic [31:0]       seq_data;
    logic              done;

    assign start_ok = (state == IDLE) && cfg_start_i
                   && (cfg_period_i != 32'h0);
    assign stop_ok  = cfg_stop_i
                   && ((state == WR_VAL) || (state == WR_ARM)
                    || (state == RUN)    || (state == WR_CLR));
    // A stop in the same cycle as an expiry discards the expiry
    assign expire   = (state == RUN) && t_int_i && !cfg_stop_i;
    assign last     = (reload_q != '0) && (cnt_q == reload_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            period_q <= '0;
            reload_q <= '0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                period_q <= cfg_period_i;
                reload_q <= cfg_reload_i;
                cnt_q    <= '0;
            end else if (expire) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (done) begin
                irq_q <= 1'b1;
            end else if (irq_ack_i) begin
                irq_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        seq_wr    = 1'b0;
        seq_addr  = '0;
        seq_data  = '0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nxt = WR_VAL;
            end
            WR_VAL: begin
                seq_wr    = 1'b1;
                seq_addr  = ADDR_VALUE;
                seq_data  = period_q;
                state_nxt = WR_ARM;
            end
            WR_ARM: begin
                seq_wr    = 1'b1;
                seq_addr  = ADDR_CTRL;
                seq_data  = CTRL_ARM;
                state_nxt = RUN;
            end
            RUN: begin
                if (expire) state_nxt = WR_CLR;
            end
            WR_CLR: begin
                seq_wr    = 1'b1;
                seq_addr  = ADDR_CTRL;
                seq_data  = CTRL_CLR;
                state_nxt = last ? IDLE : WR_ARM;
                done      = last;
            end
            WR_STOP: begin
                seq_wr    = 1'b1;
                seq_addr  = ADDR_CTRL;
                seq_data  = CTRL_CLR;
                state_nxt = IDLE;
                done      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (stop_ok) begin
            state_nxt = WR_STOP;
            done      = 1'b0;
        end
    end

    // Host owns the timer port whenever the sequencer is not writing
    always_comb begin
        if (seq_wr) begin
            t_req_o  = 1'b1;
            t_we_o   = 1'b1;
            t_addr_o = seq_addr;
            t_data_o = seq_data;
            m_ack_o  = 1'b0;
            m_data_o = '0;
        end else begin
            t_req_o  = m_req_i;
            t_we_o   = m_req_i && m_we_i;
            t_addr_o = m_addr_i;
            t_data_o = m_data_i;
            m_ack_o  = m_req_i;
            m_data_o = t_data_i;
        end
    end

    assign busy_o       = (state != IDLE);
    assign done_o       = done;
    assign irq_o        = irq_q;
    assign period_cnt_o = cnt_q;

endmodule

// File: tb/tb_timer_seq.sv
// Randomized scoreboard bench for timer_seq with a behavioural
// count-up timer peripheral attached to its timer port.
module tb_timer_seq;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_start_i = 1'b0;
    logic             cfg_stop_i = 1'b0;
    logic [31:0]      cfg_period_i = '0;
    logic [CNT_W-1:0] cfg_reload_i = '0;
    logic             irq_ack_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic             irq_o;
    logic [CNT_W-1:0] period_cnt_o;
    logic             m_req_i = 1'b0;
    logic             m_we_i = 1'b0;
    logic [31:0]      m_addr_i = '0;
    logic [31:0]      m_data_i = '0;
    logic [31:0]      m_data_o;
    logic             m_ack_o;
    logic             t_req_o;
    logic             t_we_o;
    logic [31:0]      t_addr_o;
    logic [31:0]      t_data_o;
    logic [31:0]      t_data_i;
    logic             t_int_i;

    timer_seq #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i),
        .cfg_period_i(cfg_period_i), .cfg_reload_i(cfg_reload_i),
        .irq_ack_i(irq_ack_i), .busy_o(busy_o), .done_o(done_o),
        .irq_o(irq_o), .period_cnt_o(period_cnt_o),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i),
        .m_data_i(m_data_i), .m_data_o(m_data_o), .m_ack_o(m_ack_o),
        .t_req_o(t_req_o), .t_we_o(t_we_o), .t_addr_o(t_addr_o),
        .t_data_o(t_data_o), .t_data_i(t_data_i), .t_int_i(t_int_i)
    );

    always #5 clk = ~clk;

    // Behavioural timer: CTRL bit0 enable, bit1 int enable,
    // bit2 write-one-to-clear pending; expiry when count reaches VALUE.
    logic        tm_en, tm_ie, tm_pend;
    logic [31:0] tm_cnt, tm_val;
    logic        tm_ctrl_wr;

    assign tm_ctrl_wr = t_req_o && t_we_o && (t_addr_o[3:0] == 4'h0);
    assign t_int_i    = tm_pend && tm_ie;

    always_comb begin
        t_data_i = '0;
        case (t_addr_o[3:0])
            4'h0: t_data_i = {29'd0, tm_pend, tm_ie, tm_en};
            4'h4: t_data_i = tm_cnt;
            4'h8: t_data_i = tm_val;
            default: t_data_i = '0;
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            tm_en <= 1'b0; tm_ie <= 1'b0; tm_pend <= 1'b0;
            tm_cnt <= '0; tm_val <= '0;
        end else begin
            if (tm_ctrl_wr) begin
                tm_en <= t_data_o[0];
                tm_ie <= t_data_o[1];
                if (t_data_o[2]) tm_pend <= 1'b0;
                if (t_data_o[0]) tm_cnt <= '0;
            end else if (tm_en) begin
                if (tm_cnt + 32'd1 >= tm_val) begin
                    tm_cnt  <= '0;
                    tm_pend <= 1'b1;
                end else begin
                    tm_cnt <= tm_cnt + 32'd1;
                end
            end
            if (t_req_o && t_we_o && t_addr_o[3:0] == 4'h8)
                tm_val <= t_data_o;
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  n_total = 0;
    int  n_pass  = 0;

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endfunction

    // Expected timer writes for a run seeing n expiries, ending
    // either on reload completion or on a stop issued in RUN.
    function void plan(logic [31:0] p, int n, bit stopped);
        exp_wr.push_back('{32'h8, p});
        exp_wr.push_back('{32'h0, 32'h7});
        for (int i = 0; i < n; i++) begin
            exp_wr.push_back('{32'h0, 32'h4});
            if (i < n - 1 || stopped)
                exp_wr.push_back('{32'h0, 32'h7});
        end
        if (stopped) exp_wr.push_back('{32'h0, 32'h4});
        exp_done.push_back(n);
    endfunction

    // Monitor: every timer write and done pulse is popped and compared
    initial begin
        wr_t e;
        int  dn;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (t_req_o && t_we_o) begin
                    if (exp_wr.size() == 0) begin
                        n_total++;
                        $display("FAIL wr_unexpected: got %0h<=%0h required none",
                                 t_addr_o, t_data_o);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", t_addr_o, e.a);
                        chk("wr_data", t_data_o, e.d);
                    end
                end
                if (done_o) begin
                    if (exp_done.size() == 0) begin
                        n_total++;
                        $display("FAIL done_unexpected: got cnt %0d required none",
                                 period_cnt_o);
                    end else begin
                        dn = exp_done.pop_front();
                        chk("done_cnt", 32'(period_cnt_o), 32'(dn));
                    end
                end
            end
        end
    end

    function bit is_arm();
        return t_req_o && t_we_o && t_addr_o == 32'h0
            && t_data_o == 32'h7;
    endfunction

    task automatic start_run(input logic [31:0] p, input int r);
        @(posedge clk); #1;
        cfg_start_i  = 1'b1;
        cfg_period_i = p;
        cfg_reload_i = CNT_W'(r);
        @(posedge clk); #1;
        cfg_start_i  = 1'b0;
    endtask

    task automatic wait_arms(input int n);
        int seen = 0;
        int k = 0;
        while (seen < n && k < 3000) begin
            @(negedge clk);
            if (is_arm()) seen++;
            k++;
        end
        if (seen < n) begin
            n_total++;
            $display("FAIL arm_timeout: got %0d required %0d", seen, n);
        end
    endtask

    task automatic wait_done();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done_o && k < 3000);
        if (!done_o) begin
            n_total++;
            $display("FAIL done_timeout: got 0 required 1");
        end
    endtask

    task automatic stop_pulse();
        @(posedge clk); #1;
        cfg_stop_i = 1'b1;
        @(posedge clk); #1;
        cfg_stop_i = 1'b0;
    endtask

    task automatic after_done(input int n);
        @(negedge clk);
        chk("irq_set", 32'(irq_o), 32'd1);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("final_cnt", 32'(period_cnt_o), 32'(n));
        @(posedge clk); #1;
        irq_ack_i = 1'b1;
        @(posedge clk); #1;
        irq_ack_i = 1'b0;
        @(negedge clk);
        chk("irq_cleared", 32'(irq_o), 32'd0);
    endtask

    initial begin
        int p, r, n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_cnt", 32'(period_cnt_o), 32'd0);
        chk("rst_treq", 32'(t_req_o), 32'd0);
        chk("rst_ack", 32'(m_ack_o), 32'd0);

        // Finite run of three periods
        plan(32'd10, 3, 1'b0);
        start_run(32'd10, 3);
        wait_done();
        after_done(3);

        // Infinite run stopped after twenty expiries
        plan(32'd5, 20, 1'b1);
        start_run(32'd5, 0);
        wait_arms(21);
        stop_pulse();
        wait_done();
        after_done(20);
        chk("stop_int_low", 32'(t_int_i), 32'd0);

        // Host read held across WR_ARM, then host write in IDLE
        plan(32'd6, 1, 1'b0);
        @(posedge clk); #1;
        cfg_start_i = 1'b1; cfg_period_i = 32'd6; cfg_reload_i = 1;
        @(posedge clk); #1;
        cfg_start_i = 1'b0;
        @(posedge clk); #1;
        m_req_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h4;
        @(negedge clk);
        chk("arm_ack_blocked", 32'(m_ack_o), 32'd0);
        chk("arm_rdata_zero", m_data_o, 32'd0);
        @(negedge clk);
        chk("run_ack", 32'(m_ack_o), 32'd1);
        chk("run_count0", m_data_o, tm_cnt);
        @(negedge clk);
        chk("run_count1", m_data_o, tm_cnt);
        @(posedge clk); #1;
        m_req_i = 1'b0;
        wait_done();
        after_done(1);
        exp_wr.push_back('{32'h8, 32'hCAFE_0123});
        @(posedge clk); #1;
        m_req_i = 1'b1; m_we_i = 1'b1;
        m_addr_i = 32'h8; m_data_i = 32'hCAFE_0123;
        @(negedge clk);
        chk("idle_wr_ack", 32'(m_ack_o), 32'd1);
        @(posedge clk); #1;
        m_req_i = 1'b0; m_we_i = 1'b0;
        @(negedge clk);
        chk("idle_wr_value", tm_val, 32'hCAFE_0123);

        // Stop colliding with an expiry after two expiries
        plan(32'd4, 2, 1'b1);
        start_run(32'd4, 0);
        wait_arms(3);
        n = 0;
        while (!t_int_i && n < 100) begin
            @(negedge clk);
            n++;
        end
        cfg_stop_i = 1'b1;
        @(posedge clk); #1;
        cfg_stop_i = 1'b0;
        wait_done();
        after_done(2);

        // Zero period start is ignored
        start_run(32'd0, 2);
        @(negedge clk);
        chk("zero_busy0", 32'(busy_o), 32'd0);
        repeat (4) @(negedge clk);
        chk("zero_busy1", 32'(busy_o), 32'd0);

        // Reset mid-run abandons the run silently
        exp_wr.push_back('{32'h8, 32'd10});
        exp_wr.push_back('{32'h0, 32'h7});
        start_run(32'd10, 0);
        wait_arms(1);
        n = 0;
        while (tm_cnt != 32'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_done", 32'(done_o), 32'd0);
        chk("mrst_irq", 32'(irq_o), 32'd0);
        chk("mrst_cnt", 32'(period_cnt_o), 32'd0);
        chk("mrst_treq", 32'(t_req_o), 32'd0);
        repeat (30) @(negedge clk);
        chk("mrst_wr_left", 32'(exp_wr.size()), 32'd0);

        // Ack coinciding with done keeps irq; next ack clears it
        plan(32'd3, 1, 1'b0);
        start_run(32'd3, 1);
        wait_done();
        irq_ack_i = 1'b1;
        @(negedge clk);
        chk("ack_same_cycle", 32'(irq_o), 32'd1);
        @(negedge clk);
        chk("ack_next_cycle", 32'(irq_o), 32'd0);
        irq_ack_i = 1'b0;

        // Randomized finite and stopped runs
        for (int it = 0; it < 10; it++) begin
            p = int'($urandom_range(3, 9));
            if ($urandom_range(0, 1) == 1) begin
                r = int'($urandom_range(1, 4));
                plan(32'(p), r, 1'b0);
                start_run(32'(p), r);
                wait_done();
                after_done(r);
            end else begin
                n = int'($urandom_range(0, 3));
                plan(32'(p), n, 1'b1);
                start_run(32'(p), 0);
                wait_arms(n + 1);
                stop_pulse();
                wait_done();
                after_done(n);
            end
        end

        repeat (5) @(negedge clk);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
